// File: rtl/phase_acc_pkg.sv
// phase_acc_pkg -- shared types and helpers for the phase accumulator sequencer.
//   state_t      : sequencer FSM states
//   DEG_MAX      : largest legal phase offset in degrees
//   deg_to_word  : elaboration-time degrees -> phase word (reset constants only)
package phase_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PEND  = 2'd2,   // new config shadowed, waiting for a wrap
    DRAIN = 2'd3    // stop requested, waiting for a wrap
  } state_t;

  localparam int DEG_MAX = 359;

  // floor(deg * 2^width / 360); valid for width up to 54.
  function automatic logic [63:0] deg_to_word(input int deg, input int width);
    logic [63:0] num;
    num = 64'(deg) << width;
    return num / 64'd360;
  endfunction

endpackage

// File: rtl/phase_deg_to_word.sv
// phase_deg_to_word -- combinational degrees -> phase word.
//   deg  : phase offset in degrees (0..359 meaningful)
//   word : floor(deg * 2^ACC_WIDTH / 360)
// The divide by 360 is a multiply by a rounded-up reciprocal with FRAC extra
// fraction bits. With FRAC=18 the overshoot is below 360/2^18 < 1/360, which
// is smaller than the gap between any exact quotient k/360 fraction and the
// next integer, so the floor is exact for every deg in 0..359.
module phase_deg_to_word #(
  parameter int ACC_WIDTH = 32
) (
  input  logic [8:0]           deg,
  output logic [ACC_WIDTH-1:0] word
);
  localparam int FRAC = 18;
  localparam int PW   = ACC_WIDTH + FRAC + 2;
  localparam logic [PW-1:0] ONE   = PW'(1);
  localparam logic [PW-1:0] RECIP = ((ONE << (ACC_WIDTH + FRAC)) + PW'(359)) / PW'(360);

  logic [PW-1:0] prod;
  logic          unused_prod;

  assign prod        = PW'(deg) * RECIP;
  assign word        = prod[ACC_WIDTH+FRAC-1:FRAC];
  assign unused_prod = ^{prod[PW-1:ACC_WIDTH+FRAC], prod[FRAC-1:0]};

endmodule

// File: rtl/phase_acc_sequencer.sv
// phase_acc_sequencer -- NCO-style phase accumulator with start/stop sequencing
// and glitch-free reconfiguration (new config only lands on a wrap).
// Optional offset-phase path built only when PHASE_ACC_OFFSET_EN is defined.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   start, stop             : one-cycle control pulses (stop wins)
//   cfg_valid/cfg_ready     : config handshake; cfg_tuning, cfg_phase_deg payload
//   cfg_error               : one-cycle pulse on a rejected config
//   baud_tick, gen_clock    : wrap pulse / MSB of main accumulator
//   baud_tick_offset, gen_clock_offset : same for the offset phase
//   running                 : high in RUN, PEND, DRAIN
module phase_acc_sequencer
  import phase_acc_pkg::*;
#(
  parameter int                   ACC_WIDTH     = 32,
  parameter logic [ACC_WIDTH-1:0] DEF_TUNING    = ACC_WIDTH'(3958242),
  parameter int                   DEF_PHASE_DEG = 180
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [ACC_WIDTH-1:0] cfg_tuning,
  input  logic [8:0]           cfg_phase_deg,
  output logic                 cfg_error,
  output logic                 baud_tick,
  output logic                 baud_tick_offset,
  output logic                 gen_clock,
  output logic                 gen_clock_offset,
  output logic                 running
);

  state_t               state, state_nx;
  logic [ACC_WIDTH-1:0] acc, tuning, sh_tuning;
  logic [ACC_WIDTH:0]   sum;
  logic                 active, carry, pend, apply_sh, tick_en;
  logic                 deg_ok, cfg_ok, cfg_take, cfg_bad;

  assign active    = (state != IDLE);
  assign running   = active;
  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign sum       = {1'b0, acc} + {1'b0, tuning};
  assign carry     = active & sum[ACC_WIDTH];
  assign gen_clock = acc[ACC_WIDTH-1];

  assign cfg_ok   = (cfg_tuning != '0) && deg_ok;
  assign cfg_take = cfg_valid && cfg_ready && cfg_ok;
  assign cfg_bad  = cfg_valid && cfg_ready && !cfg_ok;

  // The wrap that ends DRAIN lands the outputs in IDLE, where ticks must be
  // quiet, so that final tick is dropped.
  assign tick_en = (state_nx != IDLE);

  always_comb begin
    state_nx = state;
    apply_sh = 1'b0;
    case (state)
      IDLE:  if (start && !stop) state_nx = RUN;
      RUN:   if (stop) state_nx = DRAIN;
             else if (cfg_take) state_nx = PEND;
      PEND:  if (stop) state_nx = DRAIN;
             else if (carry) begin
               state_nx = RUN;
               apply_sh = 1'b1;
             end
      DRAIN: if (carry) begin
               state_nx = IDLE;
               apply_sh = pend;
             end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      tuning    <= DEF_TUNING;
      sh_tuning <= DEF_TUNING;
      pend      <= 1'b0;
      baud_tick <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state     <= state_nx;
      cfg_error <= cfg_bad;
      baud_tick <= carry && tick_en;
      acc       <= (active && tick_en) ? sum[ACC_WIDTH-1:0] : '0;
      // IDLE applies at once; otherwise shadow until a wrap.
      if (cfg_take && !active) tuning <= cfg_tuning;
      else if (apply_sh)       tuning <= sh_tuning;
      if (cfg_take && active)  sh_tuning <= cfg_tuning;
      if (apply_sh)                pend <= 1'b0;
      else if (cfg_take && active) pend <= 1'b1;
    end
  end

`ifdef PHASE_ACC_OFFSET_EN
  localparam logic [ACC_WIDTH-1:0] DEF_OFF = ACC_WIDTH'(deg_to_word(DEF_PHASE_DEG, ACC_WIDTH));

  logic [ACC_WIDTH-1:0] off_word, sh_off, cfg_off, p_off;
  logic [ACC_WIDTH:0]   osum;
  logic                 ocarry;

  phase_deg_to_word #(.ACC_WIDTH(ACC_WIDTH)) u_deg2word (
    .deg  (cfg_phase_deg),
    .word (cfg_off)
  );

  assign deg_ok           = (cfg_phase_deg <= 9'(DEG_MAX));
  assign p_off            = acc + off_word;
  assign osum             = {1'b0, p_off} + {1'b0, tuning};
  assign ocarry           = active & osum[ACC_WIDTH];
  // p_off is nonzero in IDLE (acc=0 plus offset), so gate its MSB.
  assign gen_clock_offset = active & p_off[ACC_WIDTH-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      off_word         <= DEF_OFF;
      sh_off           <= DEF_OFF;
      baud_tick_offset <= 1'b0;
    end else begin
      baud_tick_offset <= ocarry && tick_en;
      if (cfg_take && !active) off_word <= cfg_off;
      else if (apply_sh)       off_word <= sh_off;
      if (cfg_take && active)  sh_off <= cfg_off;
    end
  end
`else
  localparam int unused_def_deg = DEF_PHASE_DEG;
  logic unused_deg;

  assign deg_ok           = 1'b1;
  assign baud_tick_offset = 1'b0;
  assign gen_clock_offset = 1'b0;
  assign unused_deg       = ^cfg_phase_deg;
`endif

endmodule

// File: doc/phase_acc_sequencer.md
PHASE_ACC_SEQUENCER -- requirements
Module: phase_acc_sequencer

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 32: accumulator and tuning-word width in bits.
REQ-002 SHALL have parameter DEF_TUNING, default 3958242: tuning word loaded at reset (115200 baud from a 125 MHz clock).
REQ-003 SHALL have parameter DEF_PHASE_DEG, default 180: phase offset in degrees loaded at reset.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse that starts the accumulator.
REQ-007 SHALL have port stop  input  1  one-cycle pulse that requests a stop at the next wrap.
REQ-008 SHALL have port cfg_valid  input  1  new configuration offered.
REQ-009 SHALL have port cfg_ready  output  1  configuration can be accepted.
REQ-010 SHALL have port cfg_tuning  input  ACC_WIDTH  new tuning word.
REQ-011 SHALL have port cfg_phase_deg  input  9  new phase offset in degrees, 0-359.
REQ-012 SHALL have port cfg_error  output  1  one-cycle pulse on a rejected configuration.
REQ-013 SHALL have port baud_tick  output  1  one-cycle pulse at each wrap of the main accumulator.
REQ-014 SHALL have port baud_tick_offset  output  1  one-cycle pulse at each wrap of the offset phase.
REQ-015 SHALL have port gen_clock  output  1  MSB of the main accumulator.
REQ-016 SHALL have port gen_clock_offset  output  1  MSB of the offset phase.
REQ-017 SHALL have port running  output  1  high while in RUN, PEND or DRAIN.

Function
REQ-018 FSM states SHALL be: IDLE, RUN, PEND (configuration shadowed and waiting for a wrap), DRAIN (stop requested).
- IDLE->RUN on start.
- RUN->PEND on an accepted configuration.
- RUN->DRAIN on stop.
- PEND->RUN at a wrap, when the shadow configuration is applied.
- DRAIN->IDLE at a wrap; the accumulator is cleared to 0.
REQ-019 In RUN, PEND and DRAIN, the accumulator SHALL update as acc <= acc + tuning (mod 2^ACC_WIDTH) every cycle.
REQ-020 A wrap is the carry out of acc + tuning; baud_tick SHALL be registered and assert in the cycle after the carry.
REQ-021 Offset phase p_off SHALL equal acc + off_word (mod 2^ACC_WIDTH), where off_word = floor(deg * 2^ACC_WIDTH / 360).
REQ-022 baud_tick_offset SHALL be the registered carry out of p_off + tuning.
REQ-023 The first baud_tick SHALL occur ceil(2^ACC_WIDTH / tuning) cycles after start, plus 1 cycle of register latency.
REQ-024 cfg_ready SHALL be high in IDLE and RUN and low in PEND and DRAIN.
- In IDLE, an accepted configuration SHALL apply on the next cycle.
REQ-025 A configuration SHALL be rejected, with a cfg_error pulse and no state change, when cfg_tuning == 0 or cfg_phase_deg > 359.
REQ-026 Simultaneous start and stop SHALL give stop priority; in IDLE both are ignored.
REQ-027 A start pulse in RUN, PEND or DRAIN SHALL be ignored.
REQ-028 A stop pulse in PEND SHALL move the FSM to DRAIN, and the pending configuration SHALL still apply at the drain wrap.
REQ-029 In IDLE, baud_tick, baud_tick_offset, gen_clock and gen_clock_offset SHALL be 0.
REQ-030 A configuration change SHALL never produce a partial-period tick or a double tick.

Reset
REQ-031 Reset SHALL put the FSM in IDLE, with acc=0, tuning=DEF_TUNING and off_word derived from DEF_PHASE_DEG.
REQ-032 During reset all outputs SHALL be 0 except cfg_ready, which SHALL be 1.
REQ-033 Asserting reset mid-RUN SHALL discard any pending configuration immediately, with no tick.

Configuration
REQ-034 With macro PHASE_ACC_OFFSET_EN defined:
- the offset path is built;
- cfg_phase_deg is checked and applied.
REQ-035 Without PHASE_ACC_OFFSET_EN:
- baud_tick_offset and gen_clock_offset SHALL be tied to 0;
- cfg_phase_deg SHALL be ignored and never raise cfg_error;
- no offset logic SHALL be synthesized.

Structure
REQ-036 Package phase_acc_pkg SHALL hold the FSM state enum, the DEG_MAX=359 constant and a deg-to-word function.
REQ-037 Sub-module phase_deg_to_word SHALL compute off_word as combinational constant-multiply-and-shift logic.

Verification
REQ-038 The bench SHALL cover the following directed scenarios:
- Reset, then start with defaults -> first baud_tick 1086+1 cycles after start; each interval 1085 or 1086 cycles.
- Defaults with PHASE_ACC_OFFSET_EN -> first baud_tick_offset 543+1 cycles after start; thereafter midway between baud_ticks.
- cfg_tuning=0x00800000 applied in RUN -> change takes effect only after the next baud_tick; intervals then 512 cycles.
- cfg_phase_deg=90 in IDLE -> off_word=0x40000000; offset ticks lead baud_tick by ~271 cycles.
- cfg_tuning=0 and cfg_phase_deg=400 -> cfg_error pulse each time; state and tick timing unchanged.
- stop mid-RUN, then reset asserted mid-PEND -> DRAIN ends at the next wrap with running=0; reset returns all outputs to reset values.
